pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Fetch-stage front end of the MIPS datapath: owns the program counter and drives it into the PC+4 adder instance.
- Issues word fetches to instruction memory over a req/ack handshake.
- Presents {inst, inst_pc, inst_pc_plus4} to decode over a valid/ready handshake.
- Accepts branch/jump redirects from decode/execute and squashes any fetch in flight.

Parameters:
- n, 32, datapath/address width in bits.
- RESET_PC, 32'h00000000, PC value loaded on reset; bits [1:0] must be 00.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- redirect_valid  input  1  one-cycle pulse: load redirect_pc as the new fetch PC.
- redirect_pc  input  n  redirect target; bits [1:0] are ignored and forced to 00.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  n  fetch address; stable while imem_req=1.
- imem_ack  input  1  one-cycle pulse; imem_rdata is valid in the same cycle.
- imem_rdata  input  n  fetched instruction word.
- inst_valid  output  1  inst/inst_pc/inst_pc_plus4 hold a live instruction.
- inst_ready  input  1  decode accepts; a transfer occurs when inst_valid && inst_ready.
- inst  output  n  instruction word.
- inst_pc  output  n  address of inst.
- inst_pc_plus4  output  n  inst_pc + 4 (mod 2^n).

Behaviour:
- Reset (synchronous, priority over everything):
  - pc = RESET_PC, state = S_IDLE.
  - imem_req = 0, imem_addr = 0, inst_valid = 0, inst = 0, inst_pc = 0, inst_pc_plus4 = 0.
- All outputs are registered.
- States:
  - S_IDLE: next cycle imem_req = 1, imem_addr = pc, go to S_REQ. A redirect in this cycle first loads pc = redirect_pc & ~3, so the request uses the new PC.
  - S_REQ: hold imem_req and imem_addr.
    - On imem_ack with no redirect: inst = imem_rdata, inst_pc = imem_addr, inst_pc_plus4 = adder output, inst_valid = 1, pc = pc + 4, imem_req = 0, go to S_OUT.
    - On imem_ack with redirect in the same cycle: discard rdata, pc = redirect target, imem_req = 0, go to S_IDLE.
    - On redirect with no ack: pc = redirect target, go to S_DROP. imem_req and imem_addr stay unchanged (the outstanding request must complete).
  - S_DROP: hold req/addr. On imem_ack: discard rdata, imem_req = 0, go to S_IDLE. No inst_valid is ever raised for the dropped word. A further redirect here overwrites pc; the last redirect wins.
  - S_OUT: hold inst_valid and the payload stable while inst_ready = 0.
    - Redirect has priority over ready: inst_valid = 0 next cycle, pc = redirect target, go to S_IDLE.
    - Else, on inst_ready: inst_valid = 0, go to S_IDLE.
- Throughput: with zero-wait memory, one instruction per 3 cycles (IDLE → REQ → OUT). Pipelining is out of scope.
- No imem_req is ever issued while inst_valid = 1.
- Arithmetic: pc + 4 wraps modulo 2^n (32'hFFFFFFFC → 32'h00000000); there is no overflow flag.
- An imem_ack arriving in S_IDLE or S_OUT is illegal. It is ignored, and the bench must flag it.
- Reset during S_REQ or S_DROP abandons the request immediately; memory must tolerate imem_req dropping without an ack.

Decomposition:
- Shared package holds:
  - state encoding: S_IDLE = 2'd0, S_REQ = 2'd1, S_DROP = 2'd2, S_OUT = 2'd3;
  - constant PC_STEP = 4;
  - default RESET_PC.
- One sub-module: the existing adder instance, with a = pc and b = PC_STEP, producing the PC+4 value used for pc update and for inst_pc_plus4.
- FSM and registers stay in pc_fetch_unit.

Test Plan:
- Reset: hold reset 2 cycles, then release → imem_req = 0 and inst_valid = 0 during reset; first imem_req rises 1 cycle after release with imem_addr = 32'h00000000.
- Sequential fetch: ack every request in its first cycle with rdata = addr ^ 32'hA5A5A5A5, inst_ready = 1 → inst_pc = 0, 4, 8, C; inst = A5A5A5A5, A5A5A5A1, A5A5A5AD, A5A5A5A9; inst_pc_plus4 = inst_pc + 4; inst_valid asserted every 3rd cycle.
- Backpressure: hold inst_ready = 0 for 5 cycles while inst_valid = 1 → inst, inst_pc and inst_valid stay constant; imem_req stays 0; the next request goes to inst_pc + 4.
- Redirect in flight: delay ack 3 cycles and pulse redirect to 32'h00000103 in the first req cycle → imem_addr is held until ack, the old word is never presented, and the next request has imem_addr = 32'h00000100.
- Simultaneous events:
  - redirect with imem_ack → rdata discarded, next request at the redirect target;
  - redirect with inst_ready in S_OUT → inst_valid drops, next request at the redirect target rather than pc + 4.
- Wrap and reset mid-op:
  - redirect to 32'hFFFFFFFC, fetch twice → second inst_pc = 32'h00000000;
  - assert reset in S_DROP → next cycle imem_req = 0, inst_valid = 0, and the following request uses RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch front end.
// State encoding, PC step and default reset vector.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam int          PC_STEP          = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_adder.sv
// PC+4 adder; the sum wraps modulo 2^n.
// Shared by the pc update and the inst_pc_plus4 payload.
module pc_fetch_unit_adder #(
    parameter int n = 32
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word at a time over req/ack,
// hands it to decode over valid/ready, and honours redirects.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int          n        = 32,
    parameter logic [n-1:0] RESET_PC = n'(DEFAULT_RESET_PC)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         redirect_valid,
    input  logic [n-1:0] redirect_pc,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [n-1:0] imem_rdata,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [n-1:0] inst,
    output logic [n-1:0] inst_pc,
    output logic [n-1:0] inst_pc_plus4
);

    localparam logic [n-1:0] STEP  = n'(PC_STEP);
    localparam logic [n-1:0] ALIGN = ~n'(3);

    state_t       state, state_next;
    logic [n-1:0] pc, pc_next;
    logic [n-1:0] pc_sum;
    logic [n-1:0] target;

    logic         req_next;
    logic [n-1:0] addr_next;
    logic         valid_next;
    logic [n-1:0] inst_next;
    logic [n-1:0] inst_pc_next;
    logic [n-1:0] plus4_next;

    pc_fetch_unit_adder #(.n(n)) u_adder (
        .a   (pc),
        .b   (STEP),
        .sum (pc_sum)
    );

    assign target = redirect_pc & ALIGN;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            pc            <= RESET_PC;
            imem_req      <= 1'b0;
            imem_addr     <= '0;
            inst_valid    <= 1'b0;
            inst          <= '0;
            inst_pc       <= '0;
            inst_pc_plus4 <= '0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            imem_req      <= req_next;
            imem_addr     <= addr_next;
            inst_valid    <= valid_next;
            inst          <= inst_next;
            inst_pc       <= inst_pc_next;
            inst_pc_plus4 <= plus4_next;
        end
    end

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        req_next     = imem_req;
        addr_next    = imem_addr;
        valid_next   = inst_valid;
        inst_next    = inst;
        inst_pc_next = inst_pc;
        plus4_next   = inst_pc_plus4;

        unique case (state)
            S_IDLE: begin
                // A redirect here steers the request that is about to go out
                pc_next    = redirect_valid ? target : pc;
                req_next   = 1'b1;
                addr_next  = pc_next;
                state_next = S_REQ;
            end
            S_REQ: begin
                if (redirect_valid) begin
                    pc_next = target;
                    if (imem_ack) begin
                        req_next   = 1'b0;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_DROP;
                    end
                end else if (imem_ack) begin
                    inst_next    = imem_rdata;
                    inst_pc_next = imem_addr;
                    plus4_next   = pc_sum;
                    valid_next   = 1'b1;
                    pc_next      = pc_sum;
                    req_next     = 1'b0;
                    state_next   = S_OUT;
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    pc_next = target;
                end
                if (imem_ack) begin
                    req_next   = 1'b0;
                    state_next = S_IDLE;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    valid_next = 1'b0;
                    pc_next    = target;
                    state_next = S_IDLE;
                end else if (inst_ready) begin
                    valid_next = 1'b0;
                    state_next = S_IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: vector table for sequential/wrap
// fetches plus hand-written sequences for redirect, stall and reset.
module tb_pc_fetch_unit;

    localparam logic [31:0] PAT = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_valid_cyc = 0;

    int   ack_delay  = 0;
    int   wait_cnt   = 0;
    bit   inject_ack = 0;
    bit   valid_seen = 0;
    logic        prev_req  = 1'b0;
    logic [31:0] prev_addr = '0;

    typedef struct {
        bit          redir;
        logic [31:0] tgt;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [31:0] e_pc4;
        int          gap;
    } vec_t;

    vec_t vecs[6];

    pc_fetch_unit #(.n(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pc_plus4  (inst_pc_plus4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: acks after ack_delay req cycles; also watches protocol
    always @(negedge clk) begin
        if (!reset && prev_req && imem_req)
            chk("addr_stable", imem_addr, prev_addr);
        if (!reset)
            chk("req_with_valid", {31'b0, imem_req & inst_valid}, 32'h0);
        prev_req  = imem_req;
        prev_addr = imem_addr;
        if (inst_valid) valid_seen = 1;
        if (inject_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEADBEEF;
            inject_ack = 0;
        end else if (imem_req && !reset) begin
            if (wait_cnt >= ack_delay) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr ^ PAT;
                wait_cnt   = 0;
            end else begin
                imem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (inst_valid) return;
            @(negedge clk);
        end
        chk({tag, "_valid_timeout"}, 32'h1, 32'h0);
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (imem_req) return;
            @(negedge clk);
        end
        chk({tag, "_req_timeout"}, 32'h1, 32'h0);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (!imem_req && !inst_valid) return;
            @(negedge clk);
        end
        chk({tag, "_idle_timeout"}, 32'h1, 32'h0);
    endtask

    task automatic pulse_ready();
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
    endtask

    task automatic fetch_one(input vec_t v, input int idx);
        int gap;
        string tag;
        tag = $sformatf("vec%0d", idx);
        if (v.redir) begin
            wait_idle(tag);
            redirect_valid = 1'b1;
            redirect_pc    = v.tgt;
            @(negedge clk);
            redirect_valid = 1'b0;
        end
        wait_valid(tag);
        gap = cyc - last_valid_cyc;
        chk({tag, "_inst_pc"}, inst_pc, v.e_pc);
        chk({tag, "_inst"}, inst, v.e_inst);
        chk({tag, "_pc_plus4"}, inst_pc_plus4, v.e_pc4);
        if (v.gap != 0) chk({tag, "_gap"}, gap, v.gap);
        last_valid_cyc = cyc;
        pulse_ready();
        chk({tag, "_valid_drop"}, {31'b0, inst_valid}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cap_inst, cap_pc;

        vecs[0] = '{0, 32'h0,        32'h0,        32'hA5A5A5A5, 32'h4,  0};
        vecs[1] = '{0, 32'h0,        32'h4,        32'hA5A5A5A1, 32'h8,  3};
        vecs[2] = '{0, 32'h0,        32'h8,        32'hA5A5A5AD, 32'hC,  3};
        vecs[3] = '{0, 32'h0,        32'hC,        32'hA5A5A5A9, 32'h10, 3};
        vecs[4] = '{1, 32'hFFFFFFFE, 32'hFFFFFFFC, 32'h5A5A5A59, 32'h0,  0};
        vecs[5] = '{0, 32'h0,        32'h0,        32'hA5A5A5A5, 32'h4,  3};

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = '0;

        // Reset held for two cycles, then the first request follows release
        repeat (2) begin
            @(negedge clk);
            chk("rst_req", {31'b0, imem_req}, 32'h0);
            chk("rst_valid", {31'b0, inst_valid}, 32'h0);
        end
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_pc_plus4", inst_pc_plus4, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);

        for (int i = 0; i < 6; i++) fetch_one(vecs[i], i);

        // Backpressure with an illegal ack injected while the word is held
        wait_valid("bp");
        cap_inst = inst;
        cap_pc   = inst_pc;
        chk("bp_pc", cap_pc, 32'h4);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 1) inject_ack = 1;
            chk("bp_valid", {31'b0, inst_valid}, 32'h1);
            chk("bp_inst", inst, cap_inst);
            chk("bp_inst_pc", inst_pc, cap_pc);
            chk("bp_req", {31'b0, imem_req}, 32'h0);
        end
        pulse_ready();
        wait_req("bp");
        chk("bp_next_addr", imem_addr, cap_pc + 32'h4);
        wait_valid("bp2");
        pulse_ready();

        // Redirect in the first req cycle of a slow fetch
        ack_delay = 3;
        wait_idle("fly");
        @(negedge clk);
        chk("fly_req", {31'b0, imem_req}, 32'h1);
        chk("fly_addr", imem_addr, 32'hC);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00000103;
        valid_seen     = 0;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("fly_hold_addr", imem_addr, 32'hC);
        wait_idle("fly");
        chk("fly_no_valid", {31'b0, valid_seen}, 32'h0);
        @(negedge clk);
        chk("fly_new_addr", imem_addr, 32'h100);
        ack_delay = 0;
        wait_valid("fly");
        chk("fly_inst_pc", inst_pc, 32'h100);
        chk("fly_inst", inst, 32'hA5A5A4A5);
        pulse_ready();

        // Redirect coinciding with the ack
        wait_idle("rack");
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00000200;
        valid_seen     = 0;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("rack_valid", {31'b0, inst_valid}, 32'h0);
        chk("rack_req", {31'b0, imem_req}, 32'h0);
        @(negedge clk);
        chk("rack_no_valid", {31'b0, valid_seen}, 32'h0);
        chk("rack_addr", imem_addr, 32'h200);
        wait_valid("rack");
        chk("rack_inst_pc", inst_pc, 32'h200);
        pulse_ready();

        // Redirect and ready together in S_OUT
        wait_valid("rrdy");
        chk("rrdy_pc", inst_pc, 32'h204);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00000300;
        @(negedge clk);
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        chk("rrdy_valid", {31'b0, inst_valid}, 32'h0);
        wait_req("rrdy");
        chk("rrdy_addr", imem_addr, 32'h300);
        wait_valid("rrdy2");
        chk("rrdy_inst_pc", inst_pc, 32'h300);
        pulse_ready();

        // Reset while a redirected fetch is being dropped
        ack_delay = 3;
        wait_idle("rdrop");
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00000400;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("rdrop_req_held", {31'b0, imem_req}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("rdrop_req", {31'b0, imem_req}, 32'h0);
        chk("rdrop_valid", {31'b0, inst_valid}, 32'h0);
        reset     = 1'b0;
        ack_delay = 0;
        @(negedge clk);
        chk("rdrop_new_req", {31'b0, imem_req}, 32'h1);
        chk("rdrop_addr", imem_addr, 32'h0);
        wait_valid("rdrop");
        chk("rdrop_inst_pc", inst_pc, 32'h0);
        chk("rdrop_inst", inst, 32'hA5A5A5A5);
        pulse_ready();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
